dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder for the SimpleRISC pipeline: the memory-side end of the processor's DM port (ena/wea/addra/dina/douta). It holds a 128 x 32 data store with one-cycle registered reads, zero-fills the store after every reset, and offers a low-priority host req/ack port for preloading and inspecting memory. It sits beside the processor top level in place of an external BRAM.

## Interface
- ADDR_W, 7, word address width; matches the processor DM address.
- DATA_W, 32, data word width.
- DEPTH, 2**ADDR_W, number of words (128).

- clk  in  1  single clock; the processor's DMclka is this same clock.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  processor access enable.
- wea  in  1  processor write enable; qualified by ena.
- addra  in  ADDR_W  processor word address.
- dina  in  DATA_W  processor write data.
- douta  out  DATA_W  processor read data, registered.
- h_req  in  1  host request level (4-phase).
- h_we  in  1  host write when 1, read when 0; stable while h_req=1.
- h_addr  in  ADDR_W  host address; stable while h_req=1.
- h_wdata  in  DATA_W  host write data; stable while h_req=1.
- h_ack  out  1  host acknowledge.
- h_rdata  out  DATA_W  host read data; valid while h_ack=1.
- busy  out  1  high while the post-reset zero-fill runs.

## Operation
- Reset (rst=0, async): douta=0, h_ack=0, h_rdata=0, busy=1, state=CLEAR, clr_addr=0. Memory contents are not reset directly; they are rewritten by CLEAR.
- FSM states: CLEAR, IDLE, HACK.
- CLEAR: each cycle writes mem[clr_addr]=0 and increments clr_addr. At clr_addr=DEPTH-1 the state moves to IDLE and busy falls. Processor accesses are dropped and douta holds 0. h_req is not sampled.
- Processor port (IDLE and HACK):
  - ena=1, wea=1: mem[addra]<=dina; douta<=dina (write-first).
  - ena=1, wea=0: douta<=mem[addra].
  - ena=0: douta holds its value.
- Host port, processor has priority:
  - IDLE with h_req=1 and ena=0: perform the host access this edge. A write stores mem[h_addr]<=h_wdata. A read loads h_rdata<=mem[h_addr]. Set h_ack=1 and go to HACK.
  - IDLE with h_req=1 and ena=1: the host access is deferred, with no state change.
  - HACK: h_ack stays 1 and h_rdata holds. When h_req=0, clear h_ack and return to IDLE. A new request is accepted only after h_ack has been seen low.
- Only one memory write occurs per cycle, by construction.
- No out-of-range address exists because DEPTH=2**ADDR_W.
- Reset asserted mid-operation (during CLEAR, HACK, or a pending host request) aborts everything. CLEAR restarts from address 0 and any in-flight host write is lost.

## Timing
- Processor read latency: 1 cycle. Address sampled on edge N, data on douta after edge N; the pipeline captures it at edge N+1.
- Processor write: takes effect at the sampling edge. A read of the same address on the next cycle returns the new data.
- busy stays high for exactly DEPTH rising edges after rst deasserts, then falls. The first processor access is honoured on edge DEPTH+1.
- Host handshake:
  - h_ack rises 1 cycle after the edge that samples h_req=1 with ena=0.
  - h_ack falls 1 cycle after h_req=0 is sampled.
  - Minimum full handshake is 2 cycles plus the host's own turnaround.
- Host starvation is possible while ena is held high continuously. This is accepted behaviour.

## Structure
- Shared package dm_pkg:
  - state enum: ST_CLEAR, ST_IDLE, ST_HACK.
  - ADDR_W and DATA_W defaults.
- Sub-module dm_ram_core: a single-port synchronous RAM with write-first read, inferable as BRAM. The write/address mux for CLEAR, processor and host lives in dm_responder.
- dm_responder holds the FSM, clr_addr counter, priority mux and handshake registers.

## Test plan
- Reset then idle: release rst, count edges until busy=0 → exactly 128. Read all 128 addresses over the processor port → all 0.
- Processor write/read: write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle → douta=0xDEADBEEF one cycle later. Write-first check: ena=wea=1 to addr 9 with 0x12345678 → douta=0x12345678 after that edge.
- Host preload: host writes 0x000000A5 to addr 127 (h_ack rises one cycle after sampling, falls one cycle after h_req=0). Processor read of addr 127 → 0x000000A5.
- Priority: hold ena=1 for 10 cycles while h_req=1 (host read of addr 3) → h_ack stays 0. Drop ena → h_ack=1 next cycle with h_rdata=mem[3].
- CLEAR protection: during busy=1, drive ena=wea=1 addr 4 data 0xFFFFFFFF and h_req=1 → no ack and douta=0. After busy falls, mem[4] reads 0 and the host then completes.
- Mid-operation reset: assert rst while in HACK → h_ack, h_rdata, douta go to 0 immediately, busy=1. After release, CLEAR reruns for 128 cycles and previously written data reads 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and default widths for the SimpleRISC data-memory responder.
package dm_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_HACK
  } state_t;

endpackage

// File: rtl/dm_ram_core.sv
// Single-port synchronous RAM with write-first read; no reset on the array or
// the read register so synthesis can map it onto block RAM.
module dm_ram_core #(
  parameter int ADDR_W = dm_pkg::ADDR_W,
  parameter int DATA_W = dm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// Memory side of the processor DM port: zero-fills after reset, serves the
// processor with priority and a 4-phase host req/ack port when it is idle.
module dm_responder #(
  parameter int ADDR_W = dm_pkg::ADDR_W,
  parameter int DATA_W = dm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic              busy
);

  import dm_pkg::*;

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_clrAddr;
  logic [DATA_W-1:0] r_douta;
  logic [DATA_W-1:0] r_hRdata;
  logic              r_procRd;
  logic              r_hostRd;

  logic              w_ramEn;
  logic              w_ramWe;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [DATA_W-1:0] w_ramWdata;
  logic [DATA_W-1:0] w_ramRdata;
  logic              w_procAcc;
  logic              w_hostAcc;
  logic              w_hostRd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_CLEAR) begin
        r_clrAddr <= r_clrAddr + ADDR_W'(1);
      end
    end
  end

  // Single RAM port shared by the zero-fill, the processor and the host; the
  // host only gets the port when the processor leaves it unused in IDLE.
  always_comb begin
    w_nextState = r_state;
    w_ramEn     = 1'b0;
    w_ramWe     = 1'b0;
    w_ramAddr   = addra;
    w_ramWdata  = dina;
    w_procAcc   = 1'b0;
    w_hostAcc   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_ramEn    = 1'b1;
        w_ramWe    = 1'b1;
        w_ramAddr  = r_clrAddr;
        w_ramWdata = '0;
        if (r_clrAddr == LAST_ADDR) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ena) begin
          w_procAcc = 1'b1;
          w_ramEn   = 1'b1;
          w_ramWe   = wea;
        end else if (h_req) begin
          w_hostAcc   = 1'b1;
          w_ramEn     = 1'b1;
          w_ramWe     = h_we;
          w_ramAddr   = h_addr;
          w_ramWdata  = h_wdata;
          w_nextState = ST_HACK;
        end
      end
      ST_HACK: begin
        if (ena) begin
          w_procAcc = 1'b1;
          w_ramEn   = 1'b1;
          w_ramWe   = wea;
        end
        if (!h_req) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_CLEAR;
      end
    endcase
  end

  assign w_hostRd = w_hostAcc & ~h_we;

  dm_ram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ramEn),
    .i_we    (w_ramWe),
    .i_addr  (w_ramAddr),
    .i_wdata (w_ramWdata),
    .o_rdata (w_ramRdata)
  );

  // The RAM read register is shared, so each consumer sees it only in the
  // cycle after its own access and otherwise a resettable copy of what it saw.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_procRd <= 1'b0;
      r_hostRd <= 1'b0;
      r_douta  <= '0;
      r_hRdata <= '0;
    end else begin
      r_procRd <= w_procAcc;
      r_hostRd <= w_hostRd;
      r_douta  <= douta;
      r_hRdata <= h_rdata;
    end
  end

  assign douta   = r_procRd ? w_ramRdata : r_douta;
  assign h_rdata = r_hostRd ? w_ramRdata : r_hRdata;
  assign h_ack   = (r_state == ST_HACK);
  assign busy    = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, hand-written
// reset/priority sequences and a randomized run against a behavioural model.
module tb_dm_responder;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b0;
  logic              wea = 1'b0;
  logic [ADDR_W-1:0] addra = '0;
  logic [DATA_W-1:0] dina = '0;
  logic              h_req = 1'b0;
  logic              h_we = 1'b0;
  logic [ADDR_W-1:0] h_addr = '0;
  logic [DATA_W-1:0] h_wdata = '0;
  logic [DATA_W-1:0] douta;
  logic              h_ack;
  logic [DATA_W-1:0] h_rdata;
  logic              busy;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [DATA_W-1:0] modelMem [DEPTH];
  logic [DATA_W-1:0] mDout;
  logic [DATA_W-1:0] mHrd;
  logic              mAck;

  typedef struct {
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              hReq;
    logic              hWe;
    logic [ADDR_W-1:0] hAddr;
    logic [DATA_W-1:0] hWdata;
    logic [DATA_W-1:0] expDout;
    logic              expAck;
    logic [DATA_W-1:0] expHrd;
  } vec_t;

  vec_t vecs[$];

  dm_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .wea     (wea),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .h_req   (h_req),
    .h_we    (h_we),
    .h_addr  (h_addr),
    .h_wdata (h_wdata),
    .h_ack   (h_ack),
    .h_rdata (h_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic e, input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic hr, input logic hw,
                               input logic [ADDR_W-1:0] ha, input logic [DATA_W-1:0] hd);
    ena = e; wea = w; addra = a; dina = d;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy falls, tallying any ack or nonzero douta seen.
  task automatic waitClear(output int edges, output int bad);
    edges = 0;
    bad   = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (h_ack !== 1'b0 || douta !== '0) bad++;
      if (busy === 1'b0) break;
    end
  endtask

  // Spec-level behaviour for one clock edge once the zero-fill is done.
  task automatic modelStep();
    if (ena) begin
      if (wea) begin
        modelMem[addra] = dina;
        mDout = dina;
      end else begin
        mDout = modelMem[addra];
      end
    end
    if (!mAck && h_req && !ena) begin
      if (h_we) modelMem[h_addr] = h_wdata;
      else      mHrd = modelMem[h_addr];
      mAck = 1'b1;
    end else if (mAck && !h_req) begin
      mAck = 1'b0;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_douta"}, douta, mDout);
    checkOutput({tag, "_ack"}, 32'(h_ack), 32'(mAck));
    checkOutput({tag, "_hrdata"}, h_rdata, mHrd);
  endtask

  initial begin
    int edges;
    int bad;

    // Initial reset
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_douta", douta, 32'h0);
    checkOutput("rst_ack", 32'(h_ack), 32'h0);
    checkOutput("rst_hrdata", h_rdata, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);

    // Processor write and host read attempted throughout the zero-fill
    ena = 1'b1; wea = 1'b1; addra = 7'd4; dina = 32'hFFFFFFFF;
    h_req = 1'b1; h_we = 1'b0; h_addr = 7'd4; h_wdata = '0;
    rst = 1'b1;
    waitClear(edges, bad);
    checkOutput("clear_edges", 32'(edges), 32'd128);
    checkOutput("clear_protect", 32'(bad), 32'd0);
    applyStimulus(1, 0, 7'd4, 0, 1, 0, 7'd4, 0);
    checkOutput("clear_mem4", douta, 32'h0);
    checkOutput("clear_defer_ack", 32'(h_ack), 32'h0);
    applyStimulus(0, 0, 7'd4, 0, 1, 0, 7'd4, 0);
    checkOutput("clear_host_ack", 32'(h_ack), 32'h1);
    checkOutput("clear_host_rdata", h_rdata, 32'h0);
    applyStimulus(0, 0, 7'd4, 0, 0, 0, 7'd4, 0);
    checkOutput("clear_host_release", 32'(h_ack), 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, ADDR_W'(i), 0, 0, 0, 0, 0);
      checkOutput($sformatf("zero_rd%0d", i), douta, 32'h0);
    end

    // Directed cycle-by-cycle vectors
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'd5,   32'hDEADBEEF, 1'b0, 1'b0, 7'd0,   32'h0,  32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'd5,   32'h0,        1'b0, 1'b0, 7'd0,   32'h0,  32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'd9,   32'h12345678, 1'b0, 1'b0, 7'd0,   32'h0,  32'h12345678, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7'd5,   32'h0,        1'b0, 1'b0, 7'd0,   32'h0,  32'h12345678, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'd9,   32'h0,        1'b0, 1'b0, 7'd0,   32'h0,  32'h12345678, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7'd0,   32'h0,        1'b1, 1'b1, 7'd127, 32'hA5, 32'h12345678, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7'd0,   32'h0,        1'b1, 1'b1, 7'd127, 32'hA5, 32'h12345678, 1'b1, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7'd0,   32'h0,        1'b0, 1'b0, 7'd0,   32'h0,  32'h12345678, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'd127, 32'h0,        1'b0, 1'b0, 7'd0,   32'h0,  32'h000000A5, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'd5,   32'h0,        1'b1, 1'b0, 7'd9,   32'h0,  32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7'd5,   32'h0,        1'b1, 1'b0, 7'd9,   32'h0,  32'hDEADBEEF, 1'b1, 32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'd3,   32'hCAFEF00D, 1'b1, 1'b0, 7'd9,   32'h0,  32'hCAFEF00D, 1'b1, 32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7'd3,   32'h0,        1'b0, 1'b0, 7'd9,   32'h0,  32'hCAFEF00D, 1'b0, 32'h12345678});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ena, vecs[i].wea, vecs[i].addr, vecs[i].din,
                    vecs[i].hReq, vecs[i].hWe, vecs[i].hAddr, vecs[i].hWdata);
      checkOutput($sformatf("vec%0d_douta", i), douta, vecs[i].expDout);
      checkOutput($sformatf("vec%0d_ack", i), 32'(h_ack), 32'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d_hrdata", i), h_rdata, vecs[i].expHrd);
    end

    // Processor priority starves the host until ena drops
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 7'd5, 0, 1, 0, 7'd3, 0);
      checkOutput($sformatf("prio_ack%0d", i), 32'(h_ack), 32'h0);
    end
    applyStimulus(0, 0, 7'd5, 0, 1, 0, 7'd3, 0);
    checkOutput("prio_ack_rise", 32'(h_ack), 32'h1);
    checkOutput("prio_hrdata", h_rdata, 32'hCAFEF00D);
    checkOutput("prio_douta_hold", douta, 32'hDEADBEEF);
    applyStimulus(0, 0, 7'd5, 0, 0, 0, 7'd3, 0);
    checkOutput("prio_ack_fall", 32'(h_ack), 32'h0);

    // Reset while in HACK, then again partway through the zero-fill
    applyStimulus(0, 0, 7'd0, 0, 1, 0, 7'd5, 0);
    checkOutput("hack_hrdata", h_rdata, 32'hDEADBEEF);
    applyStimulus(1, 0, 7'd9, 0, 1, 0, 7'd5, 0);
    checkOutput("hack_proc_douta", douta, 32'h12345678);
    checkOutput("hack_proc_ack", 32'(h_ack), 32'h1);
    ena = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(h_ack), 32'h0);
    checkOutput("midrst_hrdata", h_rdata, 32'h0);
    checkOutput("midrst_douta", douta, 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h1);
    ena = 1'b1; wea = 1'b1; addra = 7'd4; dina = 32'hFFFFFFFF;
    h_req = 1'b1; h_we = 1'b0; h_addr = 7'd5;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("clrrst_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    waitClear(edges, bad);
    checkOutput("reclear_edges", 32'(edges), 32'd128);
    checkOutput("reclear_protect", 32'(bad), 32'd0);
    applyStimulus(0, 0, 7'd0, 0, 1, 0, 7'd5, 0);
    checkOutput("reclear_host_ack", 32'(h_ack), 32'h1);
    checkOutput("reclear_host_rdata", h_rdata, 32'h0);
    applyStimulus(0, 0, 7'd0, 0, 0, 0, 7'd5, 0);
    checkOutput("reclear_host_release", 32'(h_ack), 32'h0);
    begin
      logic [ADDR_W-1:0] probe [5];
      probe = '{7'd4, 7'd5, 7'd9, 7'd127, 7'd3};
      foreach (probe[i]) begin
        applyStimulus(1, 0, probe[i], 0, 0, 0, 0, 0);
        checkOutput($sformatf("reclear_rd%0d", probe[i]), douta, 32'h0);
      end
    end

    // Randomized traffic against the model; memory is all zero here
    foreach (modelMem[i]) modelMem[i] = '0;
    mDout = '0;
    mHrd  = '0;
    mAck  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ena   = ($urandom_range(0, 99) < 45);
      wea   = 1'($urandom_range(0, 1));
      addra = ADDR_W'($urandom_range(0, 15));
      dina  = $urandom;
      if (!h_req && !mAck && $urandom_range(0, 3) == 0) begin
        h_req   = 1'b1;
        h_we    = 1'($urandom_range(0, 1));
        h_addr  = ADDR_W'($urandom_range(0, 15));
        h_wdata = $urandom;
      end else if (h_req && mAck && $urandom_range(0, 1) == 0) begin
        h_req = 1'b0;
      end
      modelStep();
      @(posedge clk);
      #1;
      checkModel($sformatf("rnd%0d", cyc));
    end
    h_req = 1'b0;
    ena   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      modelStep();
      @(posedge clk);
      #1;
      checkModel($sformatf("drain%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; wea = 1'b0; addra = ADDR_W'(i);
      modelStep();
      @(posedge clk);
      #1;
      checkModel($sformatf("final_rd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
